// File: rtl/network_pkg.sv
// rtl/network_pkg.sv - header/rule types and scan FSM states shared by the classifier
package network_pkg;

  localparam int PROTOCOL_SIZE = 8;
  localparam int IP_SIZE       = 32;
  localparam int PORT_SIZE     = 16;

  typedef struct packed {
    logic [IP_SIZE-1:0]   ip;
    logic [PORT_SIZE-1:0] port;
  } endpoint_s;

  typedef struct packed {
    logic [PROTOCOL_SIZE-1:0] protocol;
    endpoint_s                src;
    endpoint_s                dst;
  } packet_s;

  // Each field of a rule is the half-open range [start, last).
  typedef struct packed {
    packet_s start;
    packet_s last;
  } rule_s;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT
  } scan_state_e;

endpackage

// File: rtl/rule_match.sv
// rtl/rule_match.sv - combinational test of one header against one rule
module rule_match
  import network_pkg::*;
(
  input  rule_s   rule,
  input  packet_s packet,
  output logic    matched
);

  logic proto_ok;
  logic src_ip_ok;
  logic src_port_ok;
  logic dst_ip_ok;
  logic dst_port_ok;

  // A range with last <= start is empty and can never match.
  always_comb begin
    proto_ok    = (packet.protocol >= rule.start.protocol) && (packet.protocol < rule.last.protocol);
    src_ip_ok   = (packet.src.ip   >= rule.start.src.ip)   && (packet.src.ip   < rule.last.src.ip);
    src_port_ok = (packet.src.port >= rule.start.src.port) && (packet.src.port < rule.last.src.port);
    dst_ip_ok   = (packet.dst.ip   >= rule.start.dst.ip)   && (packet.dst.ip   < rule.last.dst.ip);
    dst_port_ok = (packet.dst.port >= rule.start.dst.port) && (packet.dst.port < rule.last.dst.port);
    matched     = proto_ok && src_ip_ok && src_port_ok && dst_ip_ok && dst_port_ok;
  end

endmodule

// File: rtl/rule_scan_classifier.sv
// rtl/rule_scan_classifier.sv - linear first-match scan of an external rule RAM
module rule_scan_classifier
  import network_pkg::*;
#(
  parameter int NUM_RULES = 64,
  parameter int IDX_W     = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  input  packet_s          pkt,
  input  logic [IDX_W:0]   cfg_num_rules,
  output logic             rule_rd_en,
  output logic [IDX_W-1:0] rule_rd_addr,
  input  rule_s            rule_rd_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_rule_idx
);

  localparam logic [IDX_W:0] MAX_N = (IDX_W+1)'(NUM_RULES);

  scan_state_e      state_q, state_d;
  packet_s          pkt_q, pkt_d;
  logic [IDX_W:0]   n_q, n_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic             hit_q, hit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             issue;
  logic             matched;

  rule_match u_rule_match (
    .rule    (rule_rd_data),
    .packet  (pkt_q),
    .matched (matched)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pkt_q     <= '0;
      n_q       <= '0;
      rd_ptr_q  <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      pkt_q     <= pkt_d;
      n_q       <= n_d;
      rd_ptr_q  <= rd_ptr_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pkt_d        = pkt_q;
    n_d          = n_q;
    rd_ptr_d     = rd_ptr_q;
    cmp_vld_d    = cmp_vld_q;
    cmp_idx_d    = cmp_idx_q;
    hit_d        = hit_q;
    idx_d        = idx_q;
    issue        = 1'b0;
    pkt_ready    = 1'b0;
    rule_rd_en   = 1'b0;
    rule_rd_addr = '0;
    res_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        pkt_ready = 1'b1;
        if (pkt_valid) begin
          pkt_d     = pkt;
          n_d       = (cfg_num_rules > MAX_N) ? MAX_N : cfg_num_rules;
          rd_ptr_d  = '0;
          cmp_vld_d = 1'b0;
          hit_d     = 1'b0;
          idx_d     = '0;
          state_d   = SCAN;
        end
      end

      SCAN: begin
        issue        = (rd_ptr_q < n_q);
        rule_rd_en   = issue;
        rule_rd_addr = issue ? rd_ptr_q[IDX_W-1:0] : '0;
        cmp_vld_d    = issue;
        cmp_idx_d    = rd_ptr_q[IDX_W-1:0];
        if (issue) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // A miss is declared once every read has been issued and compared;
        // an empty table takes this path on its first SCAN cycle.
        if (cmp_vld_q && matched) begin
          hit_d   = 1'b1;
          idx_d   = cmp_idx_q;
          state_d = RESULT;
        end else if (!cmp_vld_q && (rd_ptr_q == n_q)) begin
          hit_d   = 1'b0;
          idx_d   = '0;
          state_d = RESULT;
        end
      end

      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign res_hit      = hit_q;
  assign res_rule_idx = idx_q;

endmodule

// File: tb/tb_rule_scan_classifier.sv
// tb/tb_rule_scan_classifier.sv - directed vector bench for rule_scan_classifier
module tb_rule_scan_classifier;
  import network_pkg::*;

  localparam int NR = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pkt_valid;
  logic          pkt_ready;
  packet_s       pkt;
  logic [IW:0]   cfg_num_rules;
  logic          rule_rd_en;
  logic [IW-1:0] rule_rd_addr;
  rule_s         rule_rd_data;
  logic          res_valid;
  logic          res_ready;
  logic          res_hit;
  logic [IW-1:0] res_rule_idx;

  rule_s ram [NR];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rule_rd_en) rule_rd_data <= ram[rule_rd_addr];
  end

  rule_scan_classifier #(.NUM_RULES(NR)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt           (pkt),
    .cfg_num_rules (cfg_num_rules),
    .rule_rd_en    (rule_rd_en),
    .rule_rd_addr  (rule_rd_addr),
    .rule_rd_data  (rule_rd_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_hit       (res_hit),
    .res_rule_idx  (res_rule_idx)
  );

  typedef struct {
    logic [7:0] mask;
    logic [3:0] cfg;
    logic       hit;
    int         idx;
    int         lat;
    int         maxa;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(exp));
    end
  endtask

  function automatic rule_s rule_any();
    rule_s r;
    r.start = '0;
    r.last  = '1;
    return r;
  endfunction

  function automatic packet_s base_pkt();
    packet_s p;
    p.protocol = 8'd6;
    p.src.ip   = 32'h0a00_0001;
    p.src.port = 16'd1234;
    p.dst.ip   = 32'h0a00_0002;
    p.dst.port = 16'd80;
    return p;
  endfunction

  task automatic load_mask(input logic [7:0] mask);
    for (int i = 0; i < NR; i++) ram[i] = mask[i] ? rule_any() : rule_s'('0);
  endtask

  task automatic accept(input packet_s p, input logic [3:0] cfg);
    int g;
    g = 0;
    while (!pkt_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    pkt = p;
    cfg_num_rules = cfg;
    pkt_valid = 1'b1;
    @(posedge clk); #1;
    pkt_valid = 1'b0;
    pkt = ~p;
    cfg_num_rules = ~cfg;
  endtask

  task automatic scan(input packet_s p, input logic [3:0] cfg, output int lat, output int max_addr);
    accept(p, cfg);
    max_addr = -1;
    lat = -1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (rule_rd_en && int'(rule_rd_addr) > max_addr) max_addr = int'(rule_rd_addr);
      @(posedge clk); #1;
      if (res_valid) begin
        lat = e;
        break;
      end
    end
    if (lat < 0) check("scan_timeout", 32'd1, 32'd0);
  endtask

  task automatic handshake(input string name);
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({name, "_valid_drop"}, res_valid, 1'b0);
    check({name, "_idle_ready"}, pkt_ready, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_pkt_ready"}, pkt_ready, 1'b1);
    check({name, "_rd_en"}, rule_rd_en, 1'b0);
    check({name, "_rd_addr"}, rule_rd_addr, 0);
    check({name, "_res_valid"}, res_valid, 1'b0);
    check({name, "_res_hit"}, res_hit, 1'b0);
    check({name, "_res_idx"}, res_rule_idx, 0);
  endtask

  initial begin
    int lat;
    int maxa;
    int bad_cycles;
    packet_s p;

    vecs[0] = '{8'h08, 4'd8,  1'b1, 3, 5,  4};
    vecs[1] = '{8'h24, 4'd8,  1'b1, 2, 4,  3};
    vecs[2] = '{8'h00, 4'd8,  1'b0, 0, 10, 7};
    vecs[3] = '{8'h00, 4'd0,  1'b0, 0, 1,  -1};
    vecs[4] = '{8'h01, 4'd8,  1'b1, 0, 2,  1};
    vecs[5] = '{8'h80, 4'd8,  1'b1, 7, 9,  7};
    vecs[6] = '{8'h80, 4'd7,  1'b0, 0, 9,  6};
    vecs[7] = '{8'h80, 4'd15, 1'b1, 7, 9,  7};
    vecs[8] = '{8'h00, 4'd3,  1'b0, 0, 5,  2};

    rst_n = 1'b0;
    pkt_valid = 1'b0;
    res_ready = 1'b0;
    pkt = base_pkt();
    cfg_num_rules = '0;
    load_mask(8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      load_mask(vecs[i].mask);
      scan(base_pkt(), vecs[i].cfg, lat, maxa);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_hit", i), res_hit, vecs[i].hit);
      check($sformatf("v%0d_idx", i), res_rule_idx, vecs[i].idx);
      check($sformatf("v%0d_max_addr", i), maxa, vecs[i].maxa);
      handshake($sformatf("v%0d", i));
    end

    // Half-open port range on rule 0 only.
    load_mask(8'h00);
    ram[0] = rule_any();
    ram[0].start.src.port = 16'd80;
    ram[0].last.src.port  = 16'd81;
    p = base_pkt();
    p.src.port = 16'd80;
    scan(p, 4'd1, lat, maxa);
    check("port80_hit", res_hit, 1'b1);
    check("port80_lat", lat, 2);
    handshake("port80");
    p.src.port = 16'd81;
    scan(p, 4'd1, lat, maxa);
    check("port81_miss", res_hit, 1'b0);
    check("port81_lat", lat, 3);
    handshake("port81");
    ram[0].start.src.port = 16'd0;
    ram[0].last.src.port  = 16'd0;
    p.src.port = 16'd0;
    scan(p, 4'd1, lat, maxa);
    check("last0_miss", res_hit, 1'b0);
    handshake("last0");

    // Back-pressure: result must hold while inputs churn.
    load_mask(8'h08);
    scan(base_pkt(), 4'd8, lat, maxa);
    check("hold_lat", lat, 5);
    bad_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      pkt_valid = 1'b1;
      pkt.protocol = 8'($urandom);
      pkt.src.port = 16'($urandom);
      pkt.dst.ip   = $urandom;
      cfg_num_rules = 4'($urandom);
      @(posedge clk); #1;
      if (!(res_valid === 1'b1 && res_hit === 1'b1 && res_rule_idx === 3'd3 && pkt_ready === 1'b0))
        bad_cycles++;
    end
    check("hold_bad_cycles", bad_cycles, 0);
    check("hold_idx", res_rule_idx, 3);
    pkt_valid = 1'b0;
    handshake("hold_release");

    // Reset while the scan is reading rule 4.
    load_mask(8'h80);
    accept(base_pkt(), 4'd8);
    lat = -1;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      if (rule_rd_en && rule_rd_addr == 3'd4) begin
        lat = e;
        break;
      end
    end
    check("midscan_reached_rule4", (lat >= 0), 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    bad_cycles = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) bad_cycles++;
    end
    check("midscan_no_result", bad_cycles, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_mask(8'h08);
    scan(base_pkt(), 4'd8, lat, maxa);
    check("post_reset_lat", lat, 5);
    check("post_reset_hit", res_hit, 1'b1);
    check("post_reset_idx", res_rule_idx, 3);
    handshake("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
